// File: rtl/ast_pkg.sv
// Shared request-word layout and response-entry type for the access scheduler responder.
package ast_pkg;

  // Widest source index and data word a response entry can carry.
  localparam int unsigned RESP_SRC_W  = 8;
  localparam int unsigned RESP_DATA_W = 128;

  // Request word layout {we, addr, wdata}, MSB first.
  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned addr_lsb(int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned we_bit(int unsigned addr_w, int unsigned data_w);
    return addr_w + data_w;
  endfunction

  function automatic int unsigned req_w(int unsigned addr_w, int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  typedef struct packed {
    logic [RESP_SRC_W-1:0]  src;
    logic                   we;
    logic [RESP_DATA_W-1:0] data;
  } resp_entry_t;

endpackage

// File: rtl/ast_resp_fifo.sv
// Response buffer: synchronous FIFO of response entries with head and occupancy outputs.
module ast_resp_fifo
  import ast_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  resp_entry_t       push_entry,
  input  logic              pop,
  output resp_entry_t       head,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 do_pop;

  // Upstream credit accounting guarantees a free slot for every push.
  assign do_pop = pop && (count_q != '0);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ast_responder.sv
// Target endpoint: services one request per cycle against local memory and returns
// responses in acceptance order to the originating port, throttled by credit.
module ast_responder
  import ast_pkg::*;
#(
  parameter int unsigned N_PORTS    = 8,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned LAT        = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SRC_W      = $clog2(N_PORTS),
  parameter int unsigned REQ_W      = req_w(ADDR_W, DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SRC_W-1:0]   req_src,
  input  logic [REQ_W-1:0]   req_data,
  output logic [N_PORTS-1:0] resp_valid,
  output logic [DATA_W-1:0]  resp_data,
  output logic               resp_we,
  input  logic               resp_ready,
  output logic               err_drop
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INF_W    = $clog2(LAT + 1);
  localparam int unsigned WE_BIT   = we_bit(ADDR_W, DATA_W);
  localparam int unsigned ADDR_LSB = addr_lsb(DATA_W);

  logic                accept;
  logic                src_ok;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic [LAT-1:0]      pipe_vld_q;
  resp_entry_t         pipe_q [LAT];
  resp_entry_t         stage_in;
  logic [INF_W-1:0]    inflight;

  resp_entry_t         fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                pop;
  logic                err_drop_q;

  assign req_we    = req_data[WE_BIT];
  assign req_addr  = req_data[ADDR_LSB +: ADDR_W];
  assign req_wdata = req_data[DATA_LSB +: DATA_W];
  assign src_ok    = 32'(req_src) < N_PORTS;
  assign accept    = req_valid && req_ready;

  // Bad-source writes are swallowed; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && src_ok && req_we) mem_q[req_addr] <= req_wdata;
  end

  always_comb begin
    stage_in      = '0;
    stage_in.src  = RESP_SRC_W'(req_src);
    stage_in.we   = req_we;
    stage_in.data = RESP_DATA_W'(req_we ? req_wdata : mem_q[req_addr]);
  end

  // Fixed-latency pipeline, never stalls; only valids need reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= accept && src_ok;
      for (int i = 1; i < LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= stage_in;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + INF_W'(pipe_vld_q[i]);
  end

  // Reserve a buffer slot for every response still in the pipeline.
  assign req_ready = (32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_drop_q <= 1'b0;
    else        err_drop_q <= accept && !src_ok;
  end
  assign err_drop = err_drop_q;

  ast_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (pipe_vld_q[LAT-1]),
    .push_entry (pipe_q[LAT-1]),
    .pop        (pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);
  assign pop        = resp_ready && !fifo_empty;
  assign resp_valid = fifo_empty ? '0 : (N_PORTS'(1) << fifo_head.src);
  assign resp_data  = fifo_empty ? '0 : DATA_W'(fifo_head.data);
  assign resp_we    = !fifo_empty && fifo_head.we;

endmodule

// File: tb/tb_ast_responder.sv
// Bench for ast_responder: directed vectors and random traffic against a queue-based model.
module tb_ast_responder;
  import ast_pkg::*;

  localparam int unsigned N_PORTS    = 6;
  localparam int unsigned DATA_W     = 128;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned LAT        = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SRC_W      = $clog2(N_PORTS);
  localparam int unsigned REQ_W      = req_w(ADDR_W, DATA_W);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [SRC_W-1:0]   req_src = '0;
  logic [REQ_W-1:0]   req_data = '0;
  logic [N_PORTS-1:0] resp_valid;
  logic [DATA_W-1:0]  resp_data;
  logic               resp_we;
  logic               resp_ready = 1'b0;
  logic               err_drop;

  always #5 clk = ~clk;

  ast_responder #(
    .N_PORTS    (N_PORTS),
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .LAT        (LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_we    (resp_we),
    .resp_ready (resp_ready),
    .err_drop   (err_drop)
  );

  typedef struct {
    int               src;
    bit               we;
    logic [DATA_W-1:0] data;
    int               due;
  } item_t;

  typedef struct {
    bit                v;
    int                src;
    bit                we;
    int                addr;
    logic [DATA_W-1:0] d;
    bit                rr;
    logic [N_PORTS-1:0] exp_vld;
    bit                exp_we;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  item_t             infl[$];
  item_t             fifo_m[$];
  logic [DATA_W-1:0] mem_m [16];
  bit                err_exp = 1'b0;
  int                cyc = 0;
  int                n_pass = 0;
  int                n_chk = 0;
  vec_t              vecs [6];

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic vec_t mk(bit v, int src, bit we, int addr, logic [DATA_W-1:0] d, bit rr,
                              logic [N_PORTS-1:0] ev, bit ew, logic [DATA_W-1:0] ed);
    vec_t r;
    r.v = v; r.src = src; r.we = we; r.addr = addr; r.d = d; r.rr = rr;
    r.exp_vld = ev; r.exp_we = ew; r.exp_data = ed;
    return r;
  endfunction

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive(bit v, int src, bit we, int addr, logic [DATA_W-1:0] d, bit rr);
    req_valid  = v;
    req_src    = SRC_W'(src);
    req_data   = {we, ADDR_W'(addr), d};
    resp_ready = rr;
  endtask

  // Check outputs against the model, then advance model and DUT by one clock edge.
  task automatic cycle();
    bit    rdy;
    bit    acc;
    int    addr;
    item_t it;
    rdy = (fifo_m.size() + infl.size()) < FIFO_DEPTH;
    chk("req_ready", req_ready, rdy);
    if (fifo_m.size() == 0) begin
      chk("resp_valid", resp_valid, '0);
    end else begin
      chk("resp_valid", resp_valid, DATA_W'(1 << fifo_m[0].src));
      chk("resp_we", resp_we, fifo_m[0].we);
      chk("resp_data", resp_data, fifo_m[0].data);
    end
    chk("err_drop", err_drop, err_exp);

    acc = req_valid && rdy;
    if (resp_ready && fifo_m.size() != 0) void'(fifo_m.pop_front());
    while (infl.size() != 0 && infl[0].due == cyc) fifo_m.push_back(infl.pop_front());
    err_exp = acc && (int'(req_src) >= N_PORTS);
    if (acc && int'(req_src) < N_PORTS) begin
      it.src = int'(req_src);
      it.we  = req_data[REQ_W-1];
      addr   = int'(req_data[DATA_W +: ADDR_W]);
      if (it.we) begin
        mem_m[addr] = req_data[DATA_W-1:0];
        it.data     = req_data[DATA_W-1:0];
      end else begin
        it.data = mem_m[addr];
      end
      it.due = cyc + LAT;
      infl.push_back(it);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit rr);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 0, 1'b0, 0, '0, rr);
      cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_n;
    bit got;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, '0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_resp_we", resp_we, 0);
    chk("rst_err_drop", err_drop, 0);
    rst_n = 1'b1;

    // Known memory image before any reads.
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, a % N_PORTS, 1'b1, a, rnd128(), 1'b1);
      cycle();
    end
    idle(4, 1'b1);

    // Write then read the same address from another port.
    vecs[0] = mk(1, 3, 1, 5, 128'hA5A5, 1, 6'h00, 0, '0);
    vecs[1] = mk(1, 5, 0, 5, '0,        1, 6'h00, 0, '0);
    vecs[2] = mk(0, 0, 0, 0, '0,        1, 6'h00, 0, '0);
    vecs[3] = mk(0, 0, 0, 0, '0,        1, 6'h08, 1, 128'hA5A5);
    vecs[4] = mk(0, 0, 0, 0, '0,        1, 6'h20, 0, 128'hA5A5);
    vecs[5] = mk(0, 0, 0, 0, '0,        1, 6'h00, 0, '0);
    for (int t = 0; t < 6; t++) begin
      drive(vecs[t].v, vecs[t].src, vecs[t].we, vecs[t].addr, vecs[t].d, vecs[t].rr);
      chk("vec_resp_valid", resp_valid, vecs[t].exp_vld);
      if (vecs[t].exp_vld != '0) begin
        chk("vec_resp_we", resp_we, vecs[t].exp_we);
        chk("vec_resp_data", resp_data, vecs[t].exp_data);
      end
      cycle();
    end

    // Back-pressure: six back-to-back reads while nobody drains.
    acc_n = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, k % N_PORTS, 1'b0, k, '0, 1'b0);
      if (req_ready) acc_n++;
      cycle();
    end
    chk("bp_accepts", acc_n, 4);
    chk("bp_ready_low", req_ready, 0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      drive(1'b1, 4, 1'b0, 4, '0, 1'b1);
      got = req_ready;
      cycle();
    end
    chk("bp_fifth_accepted", got, 1);
    idle(6, 1'b1);

    // Streaming reads, one per cycle, drained every cycle.
    for (int k = 0; k < 24; k++) begin
      drive(1'b1, k % N_PORTS, 1'b0, $urandom_range(15), '0, 1'b1);
      cycle();
    end
    idle(5, 1'b1);

    // Bad sources: write to addr 2 must be dropped, read must not respond.
    drive(1'b1, 7, 1'b1, 2, rnd128(), 1'b1);
    cycle();
    drive(1'b1, 6, 1'b0, 3, '0, 1'b1);
    cycle();
    idle(2, 1'b1);
    drive(1'b1, 1, 1'b0, 2, '0, 1'b1);
    cycle();
    idle(5, 1'b1);

    // Random traffic including bad sources and stalls.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(3) != 0), $urandom_range(7), $urandom_range(1),
            $urandom_range(15), rnd128(), ($urandom_range(2) != 0));
      cycle();
    end
    idle(8, 1'b1);

    // Reset with responses both buffered and in flight.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, k + 1, 1'b0, k, '0, 1'b0);
      cycle();
    end
    idle(1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", resp_valid, '0);
    chk("mid_rst_req_ready", req_ready, 1);
    infl.delete();
    fifo_m.delete();
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6, 1'b1);
    drive(1'b1, 2, 1'b0, 9, '0, 1'b1);
    cycle();
    idle(5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
